grid_loader: RTL and testbench

Upstream feeder for the systolic alignment grid. Accepts one character pair per cycle over a valid/ready handshake and assembles the two LENGTH-character strings for the grid. Drives the first-chunk boundary scores, then holds all grid inputs stable for a fixed settle window. Afterwards it signals completion and waits for an acknowledge before loading the next pair of strings.

---
 rtl/grid_loader.sv | 105 ++++++++++
 tb/tb_grid_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_loader.sv
// grid_loader: collects two LENGTH-character strings over a valid/ready
// handshake, then presents them together with the constant boundary scores
// to the systolic alignment grid for a fixed settle window. After the window
// it raises done and waits for ack before it starts loading the next pair.
module grid_loader #(
    parameter int LENGTH = 10,
    parameter int CWIDTH = 2,
    parameter int SWIDTH = 16,
    parameter int INDEL  = -1,
    parameter int SETTLE = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CWIDTH-1:0]          c1,
    input  logic [CWIDTH-1:0]          c2,
    output logic [LENGTH*CWIDTH-1:0]   s1,
    output logic [LENGTH*CWIDTH-1:0]   s2,
    output logic [(LENGTH+1)*SWIDTH-1:0] top_scores,
    output logic [LENGTH*SWIDTH-1:0]   left_scores,
    output logic                       valid,
    output logic                       done,
    input  logic                       ack
);

    localparam int IW = $clog2(LENGTH + 1);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [SW-1:0]   settle;

    // Boundary scores are elaboration-time constants: k*INDEL truncated to SWIDTH.
    for (genvar k = 0; k <= LENGTH; k++) begin : g_top
        assign top_scores[k*SWIDTH +: SWIDTH] = SWIDTH'(k * INDEL);
    end
    for (genvar j = 0; j < LENGTH; j++) begin : g_left
        assign left_scores[j*SWIDTH +: SWIDTH] = SWIDTH'((j + 1) * INDEL);
    end

    // Control FSM; in_ready/valid/done are registered alongside the state so
    // they never depend combinationally on in_valid or ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            idx      <= '0;
            settle   <= '0;
            s1       <= '0;
            s2       <= '0;
            in_ready <= 1'b1;
            valid    <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        s1[idx*CWIDTH +: CWIDTH] <= c1;
                        s2[idx*CWIDTH +: CWIDTH] <= c2;
                        if (idx == IW'(LENGTH - 1)) begin
                            idx      <= '0;
                            settle   <= SW'(SETTLE - 1);
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                            valid    <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (settle == '0) begin
                        state <= DONE;
                        valid <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        settle <= settle - SW'(1);
                    end
                end
                DONE: begin
                    if (ack) begin
                        state    <= LOAD;
                        done     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= LOAD;
                    idx      <= '0;
                    settle   <= '0;
                    in_ready <= 1'b1;
                    valid    <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_loader.sv
// Testbench for grid_loader: event-level reference model plus literal checks.
module tb_grid_loader;

    localparam int L   = 10;
    localparam int CW  = 2;
    localparam int SWD = 16;
    localparam int IND = -1;
    localparam int ST  = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic ack = 1'b0;
    logic [CW-1:0] c1 = '0;
    logic [CW-1:0] c2 = '0;
    logic in_ready, valid, done;
    logic [L*CW-1:0] s1, s2;
    logic [(L+1)*SWD-1:0] top_scores;
    logic [L*SWD-1:0] left_scores;

    // Small-geometry instance used only for the boundary-score constants.
    logic b_in_ready, b_valid, b_done;
    logic [4*2-1:0] b_s1, b_s2;
    logic [5*8-1:0] b_top;
    logic [4*8-1:0] b_left;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grid_loader #(.LENGTH(L), .CWIDTH(CW), .SWIDTH(SWD), .INDEL(IND), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .c1(c1), .c2(c2), .s1(s1), .s2(s2),
        .top_scores(top_scores), .left_scores(left_scores),
        .valid(valid), .done(done), .ack(ack)
    );

    grid_loader #(.LENGTH(4), .CWIDTH(2), .SWIDTH(8), .INDEL(-2), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(1'b0), .in_ready(b_in_ready),
        .c1(2'b00), .c2(2'b00), .s1(b_s1), .s2(b_s2),
        .top_scores(b_top), .left_scores(b_left),
        .valid(b_valid), .done(b_done), .ack(1'b0)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks strings as arrays, number of accepted pairs, and edges elapsed
    // since the last pair was accepted.
    logic [CW-1:0] m1 [L];
    logic [CW-1:0] m2 [L];
    int  n_acc = 0;
    bit  busy = 0;
    int  elapsed = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin m1[i] = '0; m2[i] = '0; end
            n_acc = 0; busy = 0; elapsed = 0;
        end else if (!busy) begin
            if (in_valid) begin
                m1[n_acc] = c1; m2[n_acc] = c2;
                n_acc++;
                if (n_acc == L) begin busy = 1; elapsed = 0; n_acc = 0; end
            end
        end else if (elapsed >= ST) begin
            if (ack) busy = 0;
        end else begin
            elapsed++;
        end
    end

    function automatic logic [L*CW-1:0] pack1();
        logic [L*CW-1:0] v;
        for (int i = 0; i < L; i++) v[i*CW +: CW] = m1[i];
        return v;
    endfunction
    function automatic logic [L*CW-1:0] pack2();
        logic [L*CW-1:0] v;
        for (int i = 0; i < L; i++) v[i*CW +: CW] = m2[i];
        return v;
    endfunction

    logic [(L+1)*SWD-1:0] exp_top;
    logic [L*SWD-1:0]     exp_left;
    initial begin
        for (int k = 0; k <= L; k++) exp_top[k*SWD +: SWD] = SWD'(k * IND);
        for (int j = 0; j < L; j++) exp_left[j*SWD +: SWD] = SWD'((j + 1) * IND);
    end

    // Compare on every falling edge.
    always @(negedge clk) begin
        chk("in_ready", 256'(in_ready), 256'(!busy));
        chk("valid", 256'(valid), 256'(busy && elapsed < ST));
        chk("done", 256'(done), 256'(busy && elapsed >= ST));
        chk("s1", 256'(s1), 256'(pack1()));
        chk("s2", 256'(s2), 256'(pack2()));
        chk("top_scores", 256'(top_scores), 256'(exp_top));
        chk("left_scores", 256'(left_scores), 256'(exp_left));
        chk("b_top", 256'(b_top), 256'(40'hF8FAFCFE00));
        chk("b_left", 256'(b_left), 256'(32'hF8FAFCFE));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    // mode 0: back-to-back, 1: alternating gaps starting idle, 2: random gaps
    task automatic load_str(input int mode, input logic [L*CW-1:0] v1,
                            input logic [L*CW-1:0] v2, output int cycles);
        int acc = 0;
        bit tog = 0;
        bit v;
        cycles = 0;
        while (acc < L && cycles < 1000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 2) != 0);
            tog = !tog;
            in_valid = v;
            c1 = v1[acc*CW +: CW];
            c2 = v2[acc*CW +: CW];
            if (v && in_ready) acc++;
            step();
            cycles++;
        end
        in_valid = 0;
        if (acc < L) chk("load_timeout", 256'(acc), 256'(L));
    endtask

    // Counts valid cycles until done, optionally poking ignored inputs.
    task automatic wait_done(input bit poke, output int vcnt);
        int cyc = 0;
        vcnt = 0;
        while (!done && cyc < 200) begin
            if (valid) vcnt++;
            if (poke) begin
                in_valid = ($urandom_range(0, 1) == 1);
                c1 = CW'($urandom); c2 = CW'($urandom);
                ack = ($urandom_range(0, 2) == 0);
            end
            step();
            cyc++;
        end
        in_valid = 0;
        ack = 0;
        if (!done) chk("done_timeout", 256'(cyc), 256'(ST));
    endtask

    task automatic ack_after(input int hold);
        repeat (hold) step();
        ack = 1;
        step();
        ack = 0;
        chk("in_ready_after_ack", 256'(in_ready), 256'(1));
        chk("done_after_ack", 256'(done), 256'(0));
    endtask

    logic [L*CW-1:0] pat1, pat2, r1, r2;
    int cyc, vc;

    initial begin
        for (int i = 0; i < L; i++) begin
            pat1[i*CW +: CW] = CW'(i % 4);
            pat2[i*CW +: CW] = CW'((3 - i) % 4);
        end

        // Reset values
        repeat (3) step();
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_valid", 256'(valid), 256'(0));
        chk("rst_s1", 256'(s1), 256'(0));
        chk("dflt_top10", 256'(top_scores[10*SWD +: SWD]), 256'(16'hFFF6));
        rst = 0;
        step();

        // Back-to-back load
        load_str(0, pat1, pat2, cyc);
        chk("b2b_cycles", 256'(cyc), 256'(10));
        chk("b2b_in_ready", 256'(in_ready), 256'(0));
        chk("b2b_s1", 256'(s1), 256'(20'h4E4E4));
        chk("b2b_s2", 256'(s2), 256'(20'hB1B1B));
        wait_done(0, vc);
        chk("b2b_valid_cycles", 256'(vc), 256'(40));
        // Hold in DONE 15 cycles, then a single-cycle ack
        ack_after(15);
        chk("held_s1", 256'(s1), 256'(20'h4E4E4));

        // Gapped load, with ignored inputs during COMPUTE
        load_str(1, pat1, pat2, cyc);
        chk("gap_cycles", 256'(cyc), 256'(20));
        chk("gap_valid", 256'(valid), 256'(1));
        wait_done(1, vc);
        chk("gap_valid_cycles", 256'(vc), 256'(40));
        chk("gap_s1", 256'(s1), 256'(20'h4E4E4));
        chk("gap_s2", 256'(s2), 256'(20'hB1B1B));
        ack_after(2);

        // Random rounds
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < L*CW; i++) begin r1[i] = 1'($urandom); r2[i] = 1'($urandom); end
            load_str(2, r1, r2, cyc);
            chk("rnd_s1", 256'(s1), 256'(r1));
            chk("rnd_s2", 256'(s2), 256'(r2));
            if (r == 2) begin
                // ack held continuously through COMPUTE: one-cycle DONE
                ack = 1;
                cyc = 0;
                while (!in_ready && cyc < 200) begin step(); cyc++; end
                ack = 0;
                chk("ackhold_ready", 256'(in_ready), 256'(1));
            end else begin
                wait_done(1, vc);
                chk("rnd_valid_cycles", 256'(vc), 256'(40));
                ack_after($urandom_range(0, 4));
            end
        end

        // Reset mid-COMPUTE
        load_str(0, pat2, pat1, cyc);
        repeat (5) step();
        rst = 1;
        #1;
        chk("midrst_valid", 256'(valid), 256'(0));
        chk("midrst_done", 256'(done), 256'(0));
        chk("midrst_in_ready", 256'(in_ready), 256'(1));
        chk("midrst_s1", 256'(s1), 256'(0));
        chk("midrst_s2", 256'(s2), 256'(0));
        step();
        step();
        rst = 0;
        step();
        repeat (5) step();
        chk("postrst_no_valid", 256'(valid), 256'(0));
        load_str(0, pat1, pat2, cyc);
        chk("postrst_s1", 256'(s1), 256'(20'h4E4E4));
        wait_done(0, vc);
        chk("postrst_valid_cycles", 256'(vc), 256'(40));
        ack_after(1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
